// File: rtl/rbm_cdk_if.sv
// Engine/host handshake bundle for the RBM CD-k phase sequencer.
// The sequencer drives starts, done levels and the current neuron vectors.
interface rbm_cdk_if #(
    parameter int NUM_VN = 3,
    parameter int NUM_HN = 3
);
    logic              start_vh;
    logic              start_hv;
    logic              done_vh;
    logic              done_hv;
    logic [NUM_VN-1:0] cur_v;
    logic [NUM_HN-1:0] cur_h;
    logic              eng_done_vh;
    logic              eng_done_hv;
    logic              receivevh;
    logic              receivehv;
    logic [NUM_HN-1:0] new_states_h;
    logic [NUM_HN-1:0] new_states_h_en;
    logic [NUM_VN-1:0] new_states_v;
    logic [NUM_VN-1:0] new_states_v_en;

    modport master (
        output start_vh, start_hv, done_vh, done_hv, cur_v, cur_h,
        input  eng_done_vh, eng_done_hv, receivevh, receivehv,
        input  new_states_h, new_states_h_en, new_states_v, new_states_v_en
    );

    modport slave (
        input  start_vh, start_hv, done_vh, done_hv, cur_v, cur_h,
        output eng_done_vh, eng_done_hv, receivevh, receivehv,
        output new_states_h, new_states_h_en, new_states_v, new_states_v_en
    );
endinterface

// File: rtl/rbm_cdk_sequencer.sv
// CD-k phase sequencer for one RBM core: drives V->H / H->V engine phases,
// host done/receive handshakes, fragment merging and the weight-update strobe.
//
// state   | meaning
// IDLE    | waiting for begin_operation
// VH_RUN  | engine computing V->H sums
// VH_WAIT | done_vh raised, waiting for receivevh
// H_COLL  | merging sampled hidden fragments
// HV_RUN  | engine computing H->V sums
// HV_WAIT | done_hv raised, waiting for receivehv
// V_COLL  | merging sampled visible fragments
// UPDATE  | update_en strobe, debug_* valid
// FINISH  | op_done strobe, busy released
module rbm_cdk_sequencer #(
    parameter int NUM_VN   = 3,
    parameter int NUM_HN   = 3,
    parameter int CD_K_MAX = 4,
    parameter int K_W      = $clog2(CD_K_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [K_W-1:0]    cfg_k,
    input  logic              begin_operation,
    input  logic [NUM_VN-1:0] init_v,
    rbm_cdk_if.master         bus,
    output logic [NUM_VN-1:0] debug_v0,
    output logic [NUM_HN-1:0] debug_h0,
    output logic [NUM_VN-1:0] debug_vk,
    output logic [NUM_HN-1:0] debug_hk,
    output logic [K_W-1:0]    step_cnt,
    output logic              busy,
    output logic              update_en,
    output logic              op_done
);
    typedef enum logic [3:0] {
        IDLE, VH_RUN, VH_WAIT, H_COLL, HV_RUN, HV_WAIT, V_COLL, UPDATE, FINISH
    } state_t;

    localparam logic [K_W-1:0] K_MAX = K_W'(CD_K_MAX);

    state_t            state;
    logic [K_W-1:0]    k_lat;
    logic [K_W-1:0]    k_eff;
    logic [NUM_VN-1:0] cur_v;
    logic [NUM_HN-1:0] cur_h;
    logic [NUM_VN-1:0] mask_v;
    logic [NUM_HN-1:0] mask_h;
    logic [NUM_VN-1:0] v_next;
    logic [NUM_HN-1:0] h_next;
    logic              start_vh_r, start_hv_r, done_vh_r, done_hv_r;
    logic              update_en_r, op_done_r;

    assign k_eff  = (cfg_k == '0) ? K_W'(1) : ((cfg_k > K_MAX) ? K_MAX : cfg_k);
    assign h_next = (cur_h & ~bus.new_states_h_en) | (bus.new_states_h & bus.new_states_h_en);
    assign v_next = (cur_v & ~bus.new_states_v_en) | (bus.new_states_v & bus.new_states_v_en);

    // Pulses are masked while frozen so a stalled strobe never lingers.
    assign bus.start_vh = start_vh_r & en;
    assign bus.start_hv = start_hv_r & en;
    assign bus.done_vh  = done_vh_r;
    assign bus.done_hv  = done_hv_r;
    assign bus.cur_v    = cur_v;
    assign bus.cur_h    = cur_h;
    assign update_en    = update_en_r & en;
    assign op_done      = op_done_r & en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k_lat       <= '0;
            step_cnt    <= '0;
            cur_v       <= '0;
            cur_h       <= '0;
            mask_v      <= '0;
            mask_h      <= '0;
            debug_v0    <= '0;
            debug_h0    <= '0;
            debug_vk    <= '0;
            debug_hk    <= '0;
            busy        <= 1'b0;
            start_vh_r  <= 1'b0;
            start_hv_r  <= 1'b0;
            done_vh_r   <= 1'b0;
            done_hv_r   <= 1'b0;
            update_en_r <= 1'b0;
            op_done_r   <= 1'b0;
        end else if (!en) begin
            start_vh_r  <= 1'b0;
            start_hv_r  <= 1'b0;
            update_en_r <= 1'b0;
            op_done_r   <= 1'b0;
        end else begin
            start_vh_r  <= 1'b0;
            start_hv_r  <= 1'b0;
            update_en_r <= 1'b0;
            op_done_r   <= 1'b0;
            case (state)
                IDLE: if (begin_operation) begin
                    cur_v      <= init_v;
                    debug_v0   <= init_v;
                    cur_h      <= '0;
                    debug_h0   <= '0;
                    debug_vk   <= '0;
                    debug_hk   <= '0;
                    k_lat      <= k_eff;
                    step_cnt   <= '0;
                    busy       <= 1'b1;
                    start_vh_r <= 1'b1;
                    state      <= VH_RUN;
                end
                VH_RUN: if (bus.eng_done_vh) begin
                    done_vh_r <= 1'b1;
                    state     <= VH_WAIT;
                end
                VH_WAIT: if (bus.receivevh) begin
                    done_vh_r <= 1'b0;
                    mask_h    <= '0;
                    state     <= H_COLL;
                end
                H_COLL: begin
                    cur_h  <= h_next;
                    mask_h <= mask_h | bus.new_states_h_en;
                    if (&(mask_h | bus.new_states_h_en)) begin
                        if (step_cnt == '0) begin
                            debug_h0   <= h_next;
                            step_cnt   <= K_W'(1);
                            start_hv_r <= 1'b1;
                            state      <= HV_RUN;
                        end else begin
                            debug_hk <= h_next;
                            if (step_cnt < k_lat) begin
                                step_cnt   <= step_cnt + K_W'(1);
                                start_hv_r <= 1'b1;
                                state      <= HV_RUN;
                            end else begin
                                update_en_r <= 1'b1;
                                state       <= UPDATE;
                            end
                        end
                    end
                end
                HV_RUN: if (bus.eng_done_hv) begin
                    done_hv_r <= 1'b1;
                    state     <= HV_WAIT;
                end
                HV_WAIT: if (bus.receivehv) begin
                    done_hv_r <= 1'b0;
                    mask_v    <= '0;
                    state     <= V_COLL;
                end
                V_COLL: begin
                    cur_v  <= v_next;
                    mask_v <= mask_v | bus.new_states_v_en;
                    if (&(mask_v | bus.new_states_v_en)) begin
                        debug_vk   <= v_next;
                        start_vh_r <= 1'b1;
                        state      <= VH_RUN;
                    end
                end
                UPDATE: begin
                    op_done_r <= 1'b1;
                    busy      <= 1'b0;
                    state     <= FINISH;
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rbm_cdk_sequencer.sv
// Directed bench for rbm_cdk_sequencer: stimulus pushes expected update results,
// a negedge monitor pops them when update_en appears.
module tb_rbm_cdk_sequencer;
    localparam int NV = 3;
    localparam int NH = 3;
    localparam int KM = 4;
    localparam int KW = $clog2(KM + 1);

    typedef struct {
        logic [NV-1:0] v0;
        logic [NH-1:0] h0;
        logic [NV-1:0] vk;
        logic [NH-1:0] hk;
        int            nvh;
        int            nhv;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic [KW-1:0] cfg_k = '0;
    logic          begin_operation = 1'b0;
    logic [NV-1:0] init_v = '0;
    logic [NV-1:0] debug_v0, debug_vk;
    logic [NH-1:0] debug_h0, debug_hk;
    logic [KW-1:0] step_cnt;
    logic          busy, update_en, op_done;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    rbm_cdk_if #(.NUM_VN(NV), .NUM_HN(NH)) bus ();

    rbm_cdk_sequencer #(.NUM_VN(NV), .NUM_HN(NH), .CD_K_MAX(KM)) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .cfg_k           (cfg_k),
        .begin_operation (begin_operation),
        .init_v          (init_v),
        .bus             (bus),
        .debug_v0        (debug_v0),
        .debug_h0        (debug_h0),
        .debug_vk        (debug_vk),
        .debug_hk        (debug_hk),
        .step_cnt        (step_cnt),
        .busy            (busy),
        .update_en       (update_en),
        .op_done         (op_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] all_out();
        return 64'({bus.start_vh, bus.start_hv, bus.done_vh, bus.done_hv, bus.cur_v, bus.cur_h,
                    debug_v0, debug_h0, debug_vk, debug_hk, step_cnt, busy, update_en, op_done});
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.start_vh;
            1:       return bus.start_hv;
            2:       return bus.done_vh;
            3:       return bus.done_hv;
            default: return op_done;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sig(input int sel, input string name);
        int n = 0;
        while (!sig(sel) && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (!sig(sel)) begin
            errors++;
            $display("FAIL wait_%s: actual 0 after %0d cycles required 1", name, n);
        end
    endtask

    task automatic frag_h(input logic [5:0] f);
        if (f[5:3] != '0) begin
            bus.new_states_h_en = f[5:3];
            bus.new_states_h    = f[2:0];
            tick();
            bus.new_states_h_en = '0;
            bus.new_states_h    = '0;
        end
    endtask

    task automatic frag_v(input logic [5:0] f);
        if (f[5:3] != '0) begin
            bus.new_states_v_en = f[5:3];
            bus.new_states_v    = f[2:0];
            tick();
            bus.new_states_v_en = '0;
            bus.new_states_v    = '0;
        end
    endtask

    // One V->H phase: start, engine done, host receive, hidden fragments {en,val}.
    task automatic run_vh(input logic [KW-1:0] step_exp, input logic [5:0] f0,
                          input logic [5:0] f1 = 6'h0, input logic [5:0] f2 = 6'h0);
        wait_sig(0, "start_vh");
        chk("step_at_start_vh", 64'(step_cnt), 64'(step_exp));
        bus.eng_done_vh = 1'b1; tick(); bus.eng_done_vh = 1'b0;
        wait_sig(2, "done_vh");
        bus.receivevh = 1'b1; tick(); bus.receivevh = 1'b0;
        frag_h(f0); frag_h(f1); frag_h(f2);
    endtask

    task automatic run_hv(input logic [KW-1:0] step_exp, input logic [5:0] f0,
                          input logic [5:0] f1 = 6'h0, input logic [5:0] f2 = 6'h0);
        wait_sig(1, "start_hv");
        chk("step_at_start_hv", 64'(step_cnt), 64'(step_exp));
        bus.eng_done_hv = 1'b1; tick(); bus.eng_done_hv = 1'b0;
        wait_sig(3, "done_hv");
        bus.receivehv = 1'b1; tick(); bus.receivehv = 1'b0;
        frag_v(f0); frag_v(f1); frag_v(f2);
    endtask

    task automatic start_op(input logic [KW-1:0] k, input logic [NV-1:0] v, input bit push,
                            input logic [NV-1:0] ev0, input logic [NH-1:0] eh0,
                            input logic [NV-1:0] evk, input logic [NH-1:0] ehk,
                            input int nvh, input int nhv);
        exp_t e;
        cfg_k = k;
        init_v = v;
        begin_operation = 1'b1;
        if (push) begin
            e.v0 = ev0; e.h0 = eh0; e.vk = evk; e.hk = ehk; e.nvh = nvh; e.nhv = nhv;
            exp_q.push_back(e);
        end
        tick();
        begin_operation = 1'b0;
    endtask

    // Monitor: counts start pulses per operation and scores each update strobe.
    int cnt_vh = 0, cnt_hv = 0;
    bit pend_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            cnt_vh = 0; cnt_hv = 0; pend_done = 1'b0;
        end else begin
            if (pend_done) begin
                chk("op_done_after_update", 64'(op_done), 64'd1);
                chk("busy_at_op_done", 64'(busy), 64'd0);
                pend_done = 1'b0;
            end
            if (bus.start_vh) cnt_vh++;
            if (bus.start_hv) cnt_hv++;
            if (update_en) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_update: actual update_en=1 required no update");
                end else begin
                    e = exp_q.pop_front();
                    chk("upd_v0", 64'(debug_v0), 64'(e.v0));
                    chk("upd_h0", 64'(debug_h0), 64'(e.h0));
                    chk("upd_vk", 64'(debug_vk), 64'(e.vk));
                    chk("upd_hk", 64'(debug_hk), 64'(e.hk));
                    chk("upd_n_start_vh", 64'(cnt_vh), 64'(e.nvh));
                    chk("upd_n_start_hv", 64'(cnt_hv), 64'(e.nhv));
                end
                pend_done = 1'b1;
            end
            if (op_done) begin
                cnt_vh = 0; cnt_hv = 0;
            end
        end
    end

    initial begin
        int hold;
        bus.eng_done_vh = 0; bus.eng_done_hv = 0; bus.receivevh = 0; bus.receivehv = 0;
        bus.new_states_h = '0; bus.new_states_h_en = '0;
        bus.new_states_v = '0; bus.new_states_v_en = '0;

        // Reset with a begin pulse held during it
        rst = 1'b1; begin_operation = 1'b1; init_v = 3'b111; cfg_k = 3'd2;
        tick(); tick();
        chk("reset_outputs", all_out(), 64'd0);
        begin_operation = 1'b0; rst = 1'b0;
        tick();
        chk("begin_during_rst_ignored", 64'(busy), 64'd0);

        // CD-1 worked example
        start_op(3'd1, 3'b101, 1'b1, 3'b101, 3'b110, 3'b011, 3'b100, 2, 1);
        chk("busy_after_begin", 64'(busy), 64'd1);
        run_vh(3'd0, {3'b011, 3'b010}, {3'b100, 3'b100});
        chk("h0_after_collect", 64'(debug_h0), 64'(3'b110));
        run_hv(3'd1, {3'b010, 3'b010}, {3'b101, 3'b001});
        chk("vk_after_collect", 64'(debug_vk), 64'(3'b011));
        run_vh(3'd1, {3'b001, 3'b000}, {3'b100, 3'b100}, {3'b010, 3'b000});
        wait_sig(4, "op_done");
        tick(); tick();

        // CD-2
        start_op(3'd2, 3'b010, 1'b1, 3'b010, 3'b001, 3'b100, 3'b010, 3, 2);
        run_vh(3'd0, {3'b111, 3'b001});
        run_hv(3'd1, {3'b111, 3'b110});
        run_vh(3'd1, {3'b111, 3'b011});
        run_hv(3'd2, {3'b111, 3'b100});
        run_vh(3'd2, {3'b111, 3'b010});
        wait_sig(4, "op_done");
        tick(); tick();

        // cfg_k=0 runs as CD-1; handshake hold, en=0 receive, begin in H_COLL, redundant enables
        start_op(3'd0, 3'b011, 1'b1, 3'b011, 3'b101, 3'b000, 3'b110, 2, 1);
        wait_sig(0, "start_vh");
        bus.eng_done_vh = 1'b1; tick(); bus.eng_done_vh = 1'b0;
        wait_sig(2, "done_vh");
        hold = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done_vh) hold++;
            tick();
        end
        chk("done_vh_hold_20", 64'(hold), 64'd20);
        en = 1'b0;
        bus.receivevh = 1'b1; tick(); bus.receivevh = 1'b0;
        tick();
        en = 1'b1;
        tick();
        chk("receive_during_en0_lost", 64'(bus.done_vh), 64'd1);
        bus.receivevh = 1'b1; tick(); bus.receivevh = 1'b0;
        chk("done_vh_dropped", 64'(bus.done_vh), 64'd0);
        init_v = 3'b000; cfg_k = 3'd3; begin_operation = 1'b1;
        tick();
        begin_operation = 1'b0;
        chk("begin_in_hcoll_v0", 64'(debug_v0), 64'(3'b011));
        frag_h({3'b011, 3'b011});
        frag_h({3'b010, 3'b000});
        chk("redundant_cur_h", 64'(bus.cur_h), 64'(3'b001));
        chk("redundant_no_complete", 64'(bus.start_hv), 64'd0);
        frag_h({3'b100, 3'b100});
        chk("redundant_final_h", 64'(bus.cur_h), 64'(3'b101));
        run_hv(3'd1, {3'b111, 3'b000});
        run_vh(3'd1, {3'b111, 3'b110});
        wait_sig(4, "op_done");
        tick(); tick();

        // Reset during V_COLL discards the operation
        start_op(3'd1, 3'b111, 1'b0, '0, '0, '0, '0, 0, 0);
        run_vh(3'd0, {3'b111, 3'b111});
        wait_sig(1, "start_hv");
        bus.eng_done_hv = 1'b1; tick(); bus.eng_done_hv = 1'b0;
        wait_sig(3, "done_hv");
        bus.receivehv = 1'b1; tick(); bus.receivehv = 1'b0;
        frag_v({3'b001, 3'b000});
        rst = 1'b1;
        tick();
        chk("reset_in_vcoll", all_out(), 64'd0);
        rst = 1'b0;
        tick();

        // Fresh run with cfg_k above CD_K_MAX (clamped to 4)
        start_op(3'd5, 3'b110, 1'b1, 3'b110, 3'b101, 3'b011, 3'b110, 5, 4);
        run_vh(3'd0, {3'b111, 3'b101});
        run_hv(3'd1, {3'b111, 3'b001});
        run_vh(3'd1, {3'b111, 3'b100});
        run_hv(3'd2, {3'b111, 3'b010});
        run_vh(3'd2, {3'b111, 3'b001});
        run_hv(3'd3, {3'b111, 3'b111});
        run_vh(3'd3, {3'b111, 3'b000});
        run_hv(3'd4, {3'b111, 3'b011});
        run_vh(3'd4, {3'b111, 3'b110});
        wait_sig(4, "op_done");
        tick(); tick(); tick();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
